// File: rtl/pc_update_unit_pkg.sv
// Shared definitions for the program-counter update unit.
// Covers the FSM encoding, the datapath widths and the offset sign-extension helper.
package pc_update_unit_pkg;

    localparam int XLEN  = 32;
    localparam int OFF_W = 8;

    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } pc_state_e;

    // Word offset -> byte offset: sign-extend and scale by 4.
    function automatic logic [XLEN-1:0] sext_word_offset(input logic signed [OFF_W-1:0] off);
        return {{(XLEN-OFF_W-2){off[OFF_W-1]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/pc_update_unit_pc_target_adder.sv
// Combinational PC+4 and branch/jump target generation.
// All arithmetic wraps modulo 2^32 without any overflow indication.
module pc_target_adder
    import pc_update_unit_pkg::*;
(
    input  logic        [XLEN-1:0]  pc_i,
    input  logic signed [OFF_W-1:0] offset_i,
    output logic        [XLEN-1:0]  next4pc_o,
    output logic        [XLEN-1:0]  target_o
);

    assign next4pc_o = pc_i + PC_INC;
    assign target_o  = next4pc_o + sext_word_offset(offset_i);

endmodule

// File: rtl/pc_update_unit.sv
// Program-counter register with next-PC selection, stall freeze and
// buffering of a branch/jump redirect that arrives while the memory is busy.
module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BUSYWAIT,
    input  logic             BRANCH,
    input  logic             JUMP,
    input  logic [OFF_W-1:0] OFFSET,
    output logic [XLEN-1:0]  PC,
    output logic [XLEN-1:0]  NEXT4PC,
    output logic             FETCH_VALID,
    output logic             REDIRECT
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redirect_q, redirect_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

    logic [XLEN-1:0] next4pc;
    logic [XLEN-1:0] target;
    logic            req;

    pc_target_adder u_target_adder (
        .pc_i      (pc_q),
        .offset_i  (OFFSET),
        .next4pc_o (next4pc),
        .target_o  (target)
    );

    // Branch and jump share one target, so both high is a single request.
    assign req = BRANCH | JUMP;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;

        unique case (state_q)
            S_WAIT: begin
                state_d = S_RUN;
            end

            S_RUN: begin
                if (BUSYWAIT) begin
                    state_d = S_STALL;
                    if (req) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = target;
                    end
                end else if (req) begin
                    pc_d       = target;
                    redirect_d = 1'b1;
                end else begin
                    pc_d = next4pc;
                end
            end

            S_STALL: begin
                if (BUSYWAIT) begin
                    // Only the first request of a stall is kept.
                    if (!pend_q && req) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = target;
                    end
                end else begin
                    state_d = S_RUN;
                    if (pend_q) begin
                        pc_d       = pend_tgt_q;
                        redirect_d = 1'b1;
                        pend_d     = 1'b0;
                    end else if (req) begin
                        pc_d       = target;
                        redirect_d = 1'b1;
                    end else begin
                        pc_d = next4pc;
                    end
                end
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_WAIT;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign PC          = pc_q;
    assign NEXT4PC     = next4pc;
    assign FETCH_VALID = (state_q != S_WAIT);
    assign REDIRECT    = redirect_q;

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
Program-counter register and next-PC selector. It sits directly upstream of the PC offset adder and the instruction cache. Each cycle it drives PC and PC+4, and computes the branch/jump target as PC+4 plus the sign-extended word offset. On a taken branch or jump it redirects to that target. While the memory hierarchy asserts BUSYWAIT it freezes, and it buffers any redirect raised during the stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and held during the post-reset wait cycle.

Ports:
CLK  input  1  system clock, rising-edge active
RESET  input  1  asynchronous, active-low reset (0 = reset asserted)
BUSYWAIT  input  1  stall request from instruction cache / data memory (OR of both)
BRANCH  input  1  beq taken (branch-enable AND ALU zero), valid in the current cycle
JUMP  input  1  unconditional jump, valid in the current cycle
OFFSET  input  8  signed word offset from the instruction
PC  output  32  address of the instruction being fetched
NEXT4PC  output  32  PC + 4, combinational from PC
FETCH_VALID  output  1  PC holds a real fetch address (low in reset and post-reset wait)
REDIRECT  output  1  one-cycle pulse on the edge where PC loads a branch/jump target

Behaviour:
- Reset, RESET=0 at any time, asynchronous:
  - PC=RESET_PC, FETCH_VALID=0, REDIRECT=0.
  - Pending-redirect flag and target register cleared; state=S_WAIT.
  - Reset during a stall discards any pending redirect.
- Arithmetic, all 32-bit modulo 2^32:
  - NEXT4PC = PC + 4.
  - TARGET = NEXT4PC + {22 copies of OFFSET[7], OFFSET, 2'b00}.
  - Wrap-around is silent; no overflow flag.
- Redirect request = BRANCH | JUMP. Both high is legal; the target is identical, so it is treated as one request.
- State S_WAIT:
  - Exactly one clock after RESET deasserts.
  - PC held at RESET_PC; BUSYWAIT, BRANCH and JUMP ignored.
  - Next edge: go to S_RUN, FETCH_VALID=1.
- State S_RUN, on each rising edge:
  - BUSYWAIT=0 and request=1: PC<=TARGET, REDIRECT=1 for the following cycle.
  - BUSYWAIT=0 and request=0: PC<=NEXT4PC, REDIRECT=0.
  - BUSYWAIT=1: PC holds. If request=1, latch TARGET into the pending register and set the pending flag. Go to S_STALL.
- State S_STALL:
  - PC holds, FETCH_VALID stays 1, REDIRECT=0.
  - If the pending flag is clear and request=1, latch TARGET and set the flag. The first capture wins; later requests during the same stall are ignored.
  - On the first edge with BUSYWAIT=0: PC<=pending target if the flag is set (REDIRECT pulse, clear flag). Otherwise apply the normal S_RUN rule using the current BRANCH/JUMP/OFFSET. Return to S_RUN.
- Latency:
  - PC changes only on rising edges. One cycle per instruction when BUSYWAIT is low.
  - A stall of N cycles adds exactly N cycles.
- OFFSET=8'hFF with a request gives TARGET=PC, a self-loop; PC must stay constant with REDIRECT pulsing every cycle.
- No combinational path from BUSYWAIT to PC.

Decomposition:
- Shared package: state encoding S_WAIT/S_RUN/S_STALL (2-bit), word size 32, offset width 8, PC increment constant 4.
- One natural sub-module, pc_target_adder: combinational PC+4 and sign-extended offset target. The FSM, PC register and pending-redirect buffer stay in pc_update_unit.

Test Plan:
- Reset/wait: RESET=0 for 3 cycles, then release. PC=0 and FETCH_VALID=0 through the first post-release edge. Then PC=4, 8, 12 on successive edges.
- Forward branch: PC=0x10, BRANCH=1, OFFSET=8'h03. Next PC=0x20 with REDIRECT=1 for one cycle, then 0x24.
- Backward jump with wrap: PC=0x0, JUMP=1, OFFSET=8'h80. Next PC=0xFFFF_FE04.
- Stall with buffered redirect: PC=0x40, BUSYWAIT=1 for 4 cycles, BRANCH=1/OFFSET=8'h02 only in the first stall cycle. PC holds 0x40 for 4 cycles, then loads 0x4C with a REDIRECT pulse.
- Reset mid-stall: capture a pending target during BUSYWAIT, then pulse RESET=0. PC=RESET_PC, pending cleared, and after release the normal S_WAIT sequence runs with no redirect.
- Self-loop and simultaneous request: BRANCH=JUMP=1, OFFSET=8'hFF at PC=0x80 for 3 cycles. PC stays 0x80 with REDIRECT=1 each cycle.
